// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier share arbiter.
package booth_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NREQ_DEF  = 4;

    // Controller states. The encoding is fixed so that the 2-bit constants in the
    // top level line up with the enum values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Round-robin successor of requester id among n requesters.
    function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/booth_share_arb_if.sv
// Request/response bus between the client FSMs and the shared multiplier arbiter.
interface booth_share_arb_if
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = $clog2(NREQ)
);

    // Request channel, one lane per requester; operands are packed lane i at [i*WIDTH +: WIDTH].
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;

    // Response channel, shared by all requesters and tagged by requester id.
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_result;

    // Client side: issues requests and consumes responses.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    // Arbiter side: grants requests and produces responses.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/booth_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from ptr with wrap and
// returns the first asserted requester as a one-hot grant plus its binary index.
// The pointer register is owned by the caller.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic w_found;
    int   w_idx;

    // Walk the requesters in priority order ptr, ptr+1, ... and keep the first hit.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (en && !w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/booth_share_arb.sv
// Round-robin share of one external combinational signed Booth multiplier among
// NREQ requesters. Operands of the winner are registered toward the multiplier,
// the product is sampled after a full settle cycle and returned with the
// requester id over a valid/ready response channel.
module booth_share_arb
    import booth_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int NREQ  = NREQ_DEF,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_share_arb_if.slave   bus,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_result
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]         r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_result;

    logic               w_grant_en;
    logic [NREQ-1:0]    w_gnt;
    logic [IDW-1:0]     w_gnt_id;
    logic               w_any_gnt;
    logic [IDW-1:0]     w_ptr_next;
    logic [WIDTH-1:0]   w_a_arr [NREQ];
    logic [WIDTH-1:0]   w_b_arr [NREQ];

    // Unpack the per-requester operand lanes so the winner can be selected by index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
        assign w_b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end

    // Grants open in IDLE, or in RESP only when the response leaves this same cycle,
    // so the next operation overlaps the response handshake. This makes rsp_ready
    // a combinational input to req_ready.
    assign w_grant_en = (r_state == ST_IDLE) ||
                        ((r_state == ST_RESP) && bus.rsp_ready);

    rr_arbiter #(
        .NREQ   (NREQ)
    ) u_arb (
        .req    (bus.req_valid),
        .ptr    (r_ptr),
        .en     (w_grant_en),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign w_any_gnt  = |w_gnt;
    assign w_ptr_next = IDW'(rr_next(int'(w_gnt_id), NREQ));

    assign bus.req_ready  = w_gnt;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign mul_a          = r_mul_a;
    assign mul_b          = r_mul_b;

    // Latch the winner's operands and id and advance the pointer on every grant;
    // with no grant everything holds so the multiplier inputs never move mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_any_gnt) begin
            r_ptr   <= w_ptr_next;
            r_id    <= w_gnt_id;
            r_mul_a <= w_a_arr[w_gnt_id];
            r_mul_b <= w_b_arr[w_gnt_id];
        end
    end

    // Controller: IDLE waits for a grant, CALC gives the multiplier one full cycle,
    // RESP presents the product until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_gnt) begin
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_state      <= ST_RESP;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_id;
                    r_rsp_result <= mul_result;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_any_gnt ? ST_CALC : ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_share_arb.sv
// Directed bench for booth_share_arb with a behavioural signed multiplier stand-in.
module tb_booth_share_arb;
    import booth_pkg::*;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [7:0] mul_result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    booth_share_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    // Stand-in for the external Booth multiplier: 4x4 signed -> 8-bit product.
    assign mul_result = 8'($signed({{4{mul_a[3]}}, mul_a}) * $signed({{4{mul_b[3]}}, mul_b}));

    booth_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        bus.req_a[i*4 +: 4] = a;
        bus.req_b[i*4 +: 4] = b;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic show_rsp();
        $display("rsp id=%0d result=0x%02h valid=%0b", bus.rsp_id, bus.rsp_result, bus.rsp_valid);
    endtask

    logic [3:0] rr_b [4] = '{4'hF, 4'h6, 4'hA, 4'h5};
    logic [7:0] rr_r [4] = '{8'hFE, 8'h0C, 8'hF4, 8'h0A};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        rst_n = 1'b1;

        // Single request: 2 * -1 = 0xFE
        tick();
        set_req(0, 4'b0010, 4'b1111);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        chk("single_gnt", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        chk("single_mul_a", mul_a, 4'h2);
        chk("single_mul_b", mul_b, 4'hF);
        chk("single_calc_valid", bus.rsp_valid, 0);
        tick();
        show_rsp();
        chk("single_rsp_valid", bus.rsp_valid, 1);
        chk("single_rsp_id", bus.rsp_id, 0);
        chk("single_rsp_result", bus.rsp_result, 8'hFE);
        tick();
        chk("single_rsp_done", bus.rsp_valid, 0);

        // Fresh pointer for the fairness run
        rst_n = 1'b0;
        #1;
        chk("rr_reset_ptr", dut.r_ptr, 0);
        tick();
        rst_n = 1'b1;

        // Round robin with all four requesters valid: order 0,1,2,3,0
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 4'h2, rr_b[i]);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            waited = 0;
            while (bus.req_ready == 0 && waited < 8) begin
                tick();
                waited++;
            end
            chk($sformatf("rr_gnt%0d", n), bus.req_ready, 32'(1 << (n % 4)));
            tick();
            chk($sformatf("rr_mul_b%0d", n), mul_b, rr_b[n % 4]);
            tick();
            show_rsp();
            chk($sformatf("rr_rsp_id%0d", n), bus.rsp_id, n % 4);
            chk($sformatf("rr_rsp_result%0d", n), bus.rsp_result, rr_r[n % 4]);
        end
        bus.req_valid = '0;
        tick();
        chk("rr_idle_valid", bus.rsp_valid, 0);
        chk("rr_ptr_after", dut.r_ptr, 1);

        // Backpressure: req1 7*-7 = 0xCF stalled 5 cycles, then req2 -8*-8 = 0x40
        set_req(1, 4'b0111, 4'b1001);
        set_req(2, 4'b1000, 4'b1000);
        bus.req_valid = 4'b0110;
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_gnt1", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        chk("bp_calc_ready", bus.req_ready, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            show_rsp();
            chk($sformatf("bp_valid%0d", c), bus.rsp_valid, 1);
            chk($sformatf("bp_id%0d", c), bus.rsp_id, 1);
            chk($sformatf("bp_result%0d", c), bus.rsp_result, 8'hCF);
            chk($sformatf("bp_ready%0d", c), bus.req_ready, 0);
            chk($sformatf("bp_mul%0d", c), {mul_a, mul_b}, 8'h79);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_gnt2", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        chk("bp_next_valid", bus.rsp_valid, 0);
        chk("bp_next_mul", {mul_a, mul_b}, 8'h88);
        tick();
        show_rsp();
        chk("bp_next_id", bus.rsp_id, 2);
        chk("bp_next_result", bus.rsp_result, 8'h40);
        tick();

        // Wrap and skip: pointer 3, only req1 valid; -1*-1 = 0x01
        chk("wrap_ptr_before", dut.r_ptr, 3);
        set_req(1, 4'hF, 4'hF);
        bus.req_valid = 4'b0010;
        #1;
        chk("wrap_gnt", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        chk("wrap_ptr_after", dut.r_ptr, 2);
        tick();
        show_rsp();
        chk("wrap_rsp_id", bus.rsp_id, 1);
        chk("wrap_rsp_result", bus.rsp_result, 8'h01);
        tick();

        // Reset during CALC discards the operation
        set_req(0, 4'h3, 4'h3);
        bus.req_valid = 4'b0001;
        #1;
        chk("mid_gnt", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("mid_ptr", dut.r_ptr, 0);
        chk("mid_mul_a", mul_a, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("mid_no_rsp%0d", c), bus.rsp_valid, 0);
        end
        rst_n = 1'b1;
        tick();
        chk("mid_no_rsp_after", bus.rsp_valid, 0);

        // Following req2 grant at full latency: -8 * 7 = 0xC8
        set_req(2, 4'b1000, 4'b0111);
        bus.req_valid = 4'b0100;
        #1;
        chk("post_gnt", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        chk("post_calc_valid", bus.rsp_valid, 0);
        chk("post_mul_a", mul_a, 4'h8);
        tick();
        show_rsp();
        chk("post_rsp_valid", bus.rsp_valid, 1);
        chk("post_rsp_id", bus.rsp_id, 2);
        chk("post_rsp_result", bus.rsp_result, 8'hC8);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
